// File: rtl/num_to_char_streamer.sv
// Multi-digit packed number to ASCII character streamer.
// Sends DIGITS characters, most significant nibble first, over a valid/ready
// handshake, with optional leading-zero blanking and hex letter decode.
module num_to_char_streamer #(
    parameter int unsigned DIGITS = 6,
    localparam int unsigned IDX_W = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    input  logic                  hex_en,
    output logic                  busy,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic [7:0]            char_data,
    output logic [IDX_W-1:0]      char_index,
    output logic                  char_last,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e              state_q;
    logic [4*DIGITS-1:0] shreg_q;
    logic [IDX_W-1:0]    idx_q;
    logic                blank_q;
    logic                hex_q;
    logic                busy_q;
    logic                valid_q;
    logic                done_q;

    logic [3:0]          nib;
    logic                is_last;

    assign nib     = shreg_q[4*DIGITS-1 -: 4];
    assign is_last = (idx_q == IDX_W'(DIGITS - 1));

    // Transfer sequencing: capture, shift on each handshake, one-cycle done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            blank_q <= 1'b0;
            hex_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shreg_q <= value;
                        hex_q   <= hex_en;
                        blank_q <= lz_blank;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (char_ready) begin
                        shreg_q <= {shreg_q[4*DIGITS-5:0], 4'h0};
                        // Any non-zero nibble, BCD or not, ends blanking.
                        if (nib != 4'h0) begin
                            blank_q <= 1'b0;
                        end
                        if (is_last) begin
                            // Park the index at 0 so it reads 0 while idle.
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ASCII decode of the registered top nibble; zero whenever nothing is offered.
    always_comb begin
        char_data = 8'h00;
        if (valid_q) begin
            if (nib <= 4'd9) begin
                // The final digit is never blanked so an all-zero value shows "0".
                if (blank_q && (nib == 4'h0) && !is_last) begin
                    char_data = 8'h20;
                end else begin
                    char_data = {4'h3, nib};
                end
            end else if (hex_q) begin
                char_data = 8'h37 + {4'h0, nib};
            end else begin
                char_data = 8'h20;
            end
        end
    end

    assign busy       = busy_q;
    assign char_valid = valid_q;
    assign char_index = idx_q;
    assign char_last  = valid_q & is_last;
    assign done       = done_q;

endmodule
